// File: rtl/systolic_skew_feeder_if.sv
// Load handshake and skewed array-edge outputs of the systolic skew feeder.
interface systolic_skew_feeder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    load_valid_i;
    logic                    load_ready_o;
    logic [4*DATA_WIDTH-1:0] load_a_i;
    logic [4*DATA_WIDTH-1:0] load_b_i;
    logic [DATA_WIDTH-1:0]   left_o_0;
    logic [DATA_WIDTH-1:0]   left_o_4;
    logic [DATA_WIDTH-1:0]   left_o_8;
    logic [DATA_WIDTH-1:0]   left_o_12;
    logic [DATA_WIDTH-1:0]   up_o_0;
    logic [DATA_WIDTH-1:0]   up_o_1;
    logic [DATA_WIDTH-1:0]   up_o_2;
    logic [DATA_WIDTH-1:0]   up_o_3;
    logic                    clear_o;
    logic                    feed_valid_o;
    logic                    done_o;

    // Loader / observer side
    modport master (
        output load_valid_i, load_a_i, load_b_i,
        input  load_ready_o, left_o_0, left_o_4, left_o_8, left_o_12,
        input  up_o_0, up_o_1, up_o_2, up_o_3, clear_o, feed_valid_o, done_o
    );

    // Feeder side
    modport slave (
        input  load_valid_i, load_a_i, load_b_i,
        output load_ready_o, left_o_0, left_o_4, left_o_8, left_o_12,
        output up_o_0, up_o_1, up_o_2, up_o_3, clear_o, feed_valid_o, done_o
    );
endinterface

// File: rtl/systolic_skew_feeder.sv
// Loads a 4x4 A and B in four beats, then streams them diagonally skewed
// onto the left and top edges of a 4x4 systolic array.
module systolic_skew_feeder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    systolic_skew_feeder_if.slave bus
);
    typedef enum logic [2:0] {LOAD, PRIME, STREAM, DRAIN, DONE} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  beat_reg, beat_next;
    logic [2:0]  cnt_reg, cnt_next;   // stream index t, reused as drain counter
    logic        accept;

    // a_mem[row][col], b_mem[row][col]
    logic [DATA_WIDTH-1:0] a_mem [4][4];
    logic [DATA_WIDTH-1:0] b_mem [4][4];

    // Next-state, counter and handshake decode
    always_comb begin
        state_next = state_reg;
        beat_next  = beat_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        case (state_reg)
            LOAD: begin
                if (bus.load_valid_i) begin
                    accept    = 1'b1;
                    beat_next = beat_reg + 2'd1;
                    if (beat_reg == 2'd3) state_next = PRIME;
                end
            end
            PRIME: begin
                state_next = STREAM;
                cnt_next   = 3'd0;
            end
            STREAM: begin
                if (cnt_reg == 3'd6) begin
                    state_next = DRAIN;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt_reg + 3'd1;
                end
            end
            DRAIN: begin
                if (cnt_reg == 3'd2) state_next = DONE;
                else                 cnt_next   = cnt_reg + 3'd1;
            end
            DONE: begin
                state_next = LOAD;
                beat_next  = 2'd0;
            end
            default: begin
                state_next = LOAD;
                beat_next  = 2'd0;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= LOAD;
            beat_reg  <= 2'd0;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Capture A row k and B column k on each accepted beat; contents are
    // only exposed after a complete load, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            for (int j = 0; j < 4; j++) begin
                a_mem[beat_reg][j] <= bus.load_a_i[DATA_WIDTH*j +: DATA_WIDTH];
                b_mem[j][beat_reg] <= bus.load_b_i[DATA_WIDTH*j +: DATA_WIDTH];
            end
        end
    end

    // Per-lane skew: lane gi lags by gi cycles. The output registers are
    // loaded from the next-cycle index so the value for t appears together
    // with feed_valid_o in stream cycle t.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [3:0]            offset;
            logic                  in_window;
            logic [DATA_WIDTH-1:0] left_reg;
            logic [DATA_WIDTH-1:0] up_reg;

            assign offset    = {1'b0, cnt_next} - 4'(gi);
            assign in_window = (state_next == STREAM) && (offset < 4'd4);

            // Registered lane outputs, zero outside the active diagonal
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    left_reg <= '0;
                    up_reg   <= '0;
                end else if (in_window) begin
                    left_reg <= a_mem[gi][offset[1:0]];
                    up_reg   <= b_mem[offset[1:0]][gi];
                end else begin
                    left_reg <= '0;
                    up_reg   <= '0;
                end
            end
        end
    endgenerate

    assign bus.left_o_0     = g_lane[0].left_reg;
    assign bus.left_o_4     = g_lane[1].left_reg;
    assign bus.left_o_8     = g_lane[2].left_reg;
    assign bus.left_o_12    = g_lane[3].left_reg;
    assign bus.up_o_0       = g_lane[0].up_reg;
    assign bus.up_o_1       = g_lane[1].up_reg;
    assign bus.up_o_2       = g_lane[2].up_reg;
    assign bus.up_o_3       = g_lane[3].up_reg;
    assign bus.load_ready_o = (state_reg == LOAD);
    assign bus.clear_o      = (state_reg == PRIME);
    assign bus.feed_valid_o = (state_reg == STREAM);
    assign bus.done_o       = (state_reg == DONE);
endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the element width in bits.
REQ-002 The block SHALL have a fixed array order N = 4; N is not a parameter.
REQ-003 Port clk_i, input, 1 bit: the single clock; all logic SHALL be rising-edge clocked.
REQ-004 Port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port load_valid_i, input, 1 bit: the load beat is valid.
REQ-006 Port load_ready_o, output, 1 bit: the feeder accepts a load beat.
REQ-007 Port load_a_i, input, 4*DATA_WIDTH bits: one row of A; element j is at bits [DATA_WIDTH*j +: DATA_WIDTH].
REQ-008 Port load_b_i, input, 4*DATA_WIDTH bits: one column of B; element j (row index) is at bits [DATA_WIDTH*j +: DATA_WIDTH].
REQ-009 Ports left_o_0, left_o_4, left_o_8, left_o_12, outputs, DATA_WIDTH bits each: skewed A rows 0..3 driven to the array's left inputs.
REQ-010 Ports up_o_0, up_o_1, up_o_2, up_o_3, outputs, DATA_WIDTH bits each: skewed B columns 0..3 driven to the array's top inputs.
REQ-011 Port clear_o, output, 1 bit: one-cycle pulse that clears the array accumulators.
REQ-012 Port feed_valid_o, output, 1 bit: high during the STREAM state.
REQ-013 Port done_o, output, 1 bit: one-cycle pulse when the array result is final.

Function
REQ-014 The FSM SHALL have exactly the states LOAD, PRIME, STREAM, DRAIN and DONE.
REQ-015 In LOAD, load_ready_o SHALL be 1; beat k (k = 0..3, counted by a 2-bit beat counter) SHALL be accepted when load_valid_i && load_ready_o, storing A row k and B column k.
REQ-016 Acceptance of beat 3 SHALL move the FSM to PRIME on the next cycle; load_ready_o SHALL be 0 in every state other than LOAD.
REQ-017 load_valid_i SHALL be ignored outside LOAD, and stored A/B contents SHALL NOT change outside LOAD.
REQ-018 PRIME SHALL last 1 cycle, with clear_o = 1 and all data outputs 0.
REQ-019 STREAM SHALL last 2N-1 = 7 cycles, indexed t = 0..6 by a 3-bit counter, with feed_valid_o = 1.
REQ-020 In STREAM cycle t, left row r SHALL equal A[r][t-r] when 0 <= t-r <= 3, else 0.
REQ-021 In STREAM cycle t, up column c SHALL equal B[t-c][c] when 0 <= t-c <= 3, else 0.
REQ-022 All data outputs SHALL be registered; the value for cycle t SHALL be visible in the same cycle that feed_valid_o indicates index t.
REQ-023 DRAIN SHALL last N-1 = 3 cycles with all data outputs 0, covering propagation to PE(3,3).
REQ-024 DONE SHALL last 1 cycle with done_o = 1, then the FSM SHALL return to LOAD with the beat counter at 0.
REQ-025 Total latency from acceptance of beat 3 to done_o SHALL be 12 cycles (1 PRIME + 7 STREAM + 3 DRAIN + DONE on the 12th).
REQ-026 A load_valid_i held high in DONE SHALL NOT be accepted until the first LOAD cycle.
REQ-027 Elements SHALL be passed through unmodified, with no arithmetic and no width change.
REQ-028 load_valid_i toggling between beats SHALL NOT reset the beat counter; only rst_i does.

Reset
REQ-029 While rst_i is 1 at a clock edge, the FSM SHALL go to LOAD, the beat and stream counters SHALL clear, and all data outputs, clear_o, feed_valid_o and done_o SHALL be 0.
REQ-030 After the reset edge, load_ready_o SHALL be 1.
REQ-031 Reset asserted mid-LOAD, mid-STREAM or mid-DRAIN SHALL abort the operation with no done_o pulse.
REQ-032 Stored matrix contents need not be reset; they SHALL NOT be observable at the outputs before a full reload.

Verification
REQ-033 The bench SHALL cover the reference matrices: load A = rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} and B with B[r][c] = c+1 -> STREAM t=0: left_o_0=1, up_o_0=1, all others 0; t=1: left_o_0=2, left_o_4=5, up_o_0=1, up_o_1=2; t=3: left_o_0=4, left_o_12=13, up_o_3=4; t=6: left_o_12=16, up_o_3=4, others 0.
REQ-034 The bench SHALL cover timing: with beat 3 accepted at cycle T -> clear_o at T+1, feed_valid_o over T+2..T+8, zero outputs over T+9..T+11, done_o at T+12 only.
REQ-035 The bench SHALL cover gapped loads: load_valid_i low for 2 cycles between beats 1 and 2 -> exactly 4 beats accepted and STREAM identical to REQ-033.
REQ-036 The bench SHALL cover reset at STREAM t=3 -> next cycle all outputs 0, load_ready_o=1, no done_o; a subsequent full load streams correctly.
REQ-037 The bench SHALL cover back-to-back runs: load_valid_i held high throughout -> second load begins only after done_o, and the second result is correct.
REQ-038 The bench SHALL cover DATA_WIDTH=32 with all elements 32'hFFFFFFFF -> outputs carry 32'hFFFFFFFF unaltered in the active skew positions.
